// File: rtl/majority_pkg.sv
// Shared types and helpers for the majority/threshold voter with debounce.
package majority_pkg;

  localparam int N_DEF    = 5;
  localparam int HOLD_DEF = 3;
  localparam int CW       = $clog2(N_DEF + 1);
  localparam int HW       = $clog2(HOLD_DEF + 1);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } db_state_e;

  function automatic logic [CW-1:0] popcount(input logic [N_DEF-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N_DEF; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/majority_vote_debounce_popcount_tree.sv
// Combinational balanced adder tree: counts the ones in an N-bit vector.
module popcount_tree #(
  parameter int N  = 5,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  bits,
  output logic [CW-1:0] count
);
  import majority_pkg::*;

  generate
    if (N == 1) begin : g_leaf
      assign count = CW'(bits[0]);
    end else begin : g_node
      localparam int NL = N / 2;
      localparam int NR = N - NL;
      localparam int CL = $clog2(NL + 1);
      localparam int CR = $clog2(NR + 1);

      logic [CL-1:0] cl;
      logic [CR-1:0] cr;

      popcount_tree #(.N(NL), .CW(CL)) u_lo (.bits(bits[NL-1:0]), .count(cl));
      popcount_tree #(.N(NR), .CW(CR)) u_hi (.bits(bits[N-1:NL]), .count(cr));

      assign count = CW'(cl) + CW'(cr);
    end
  endgenerate

endmodule

// File: rtl/majority_vote_debounce.sv
// Two-stage N-channel threshold voter with enable mask and a hysteresis
// state machine that flips the vote only after HOLD disagreeing samples.
module majority_vote_debounce #(
  parameter int   N          = 5,
  parameter int   CW         = $clog2(N + 1),
  parameter int   HOLD       = 3,
  parameter int   HW         = $clog2(HOLD + 1),
  parameter logic RESET_VOTE = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [N-1:0]  in_bits,
  input  logic [N-1:0]  mask,
  input  logic [CW-1:0] thr,
  output logic          out_vld,
  output logic [CW-1:0] count,
  output logic          raw,
  output logic          vote,
  output logic          flip,
  output logic          dissent
);
  import majority_pkg::*;

  function automatic logic dissent_of(input logic [CW-1:0] c,
                                      input logic [CW-1:0] a,
                                      input logic          r);
    if (r) return (c != '0) && (c < a);
    return c != '0;
  endfunction

  logic [CW-1:0] act_c;
  logic          vld_p1;
  logic [N-1:0]  m_p1;
  logic [CW-1:0] act_p1;
  logic [CW-1:0] thr_p1;
  logic [CW-1:0] count_c;
  logic          raw_c;

  db_state_e     state, state_n;
  logic [HW-1:0] dc, dc_n, dc_eff;
  logic          vote_n, flip_n;

  popcount_tree #(.N(N), .CW(CW)) u_act (.bits(mask), .count(act_c));

  // Stage 1: capture masked votes, active-channel count and threshold
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      m_p1   <= '0;
      act_p1 <= '0;
      thr_p1 <= '0;
    end else begin
      vld_p1 <= in_vld;
      if (in_vld) begin
        m_p1   <= in_bits & mask;
        act_p1 <= act_c;
        thr_p1 <= thr;
      end
    end
  end

  popcount_tree #(.N(N), .CW(CW)) u_cnt (.bits(m_p1), .count(count_c));

  assign raw_c = (count_c >= thr_p1);

  // Stage 2: decision registers; values hold between valid samples
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      count   <= '0;
      raw     <= 1'b0;
      dissent <= 1'b0;
    end else begin
      out_vld <= vld_p1;
      if (vld_p1) begin
        count   <= count_c;
        raw     <= raw_c;
        dissent <= dissent_of(count_c, act_p1, raw_c);
      end
    end
  end

  always_comb begin
    dc_eff  = (state == PENDING) ? dc : '0;
    state_n = state;
    dc_n    = dc;
    vote_n  = vote;
    flip_n  = 1'b0;
    if (vld_p1) begin
      if (raw_c == vote) begin
        state_n = STABLE;
        dc_n    = '0;
      end else if (int'(dc_eff) + 1 == HOLD) begin
        vote_n  = raw_c;
        flip_n  = 1'b1;
        dc_n    = '0;
        state_n = STABLE;
      end else begin
        dc_n    = dc_eff + HW'(1);
        state_n = PENDING;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STABLE;
      dc    <= '0;
      vote  <= RESET_VOTE;
      flip  <= 1'b0;
    end else begin
      state <= state_n;
      dc    <= dc_n;
      vote  <= vote_n;
      flip  <= flip_n;
    end
  end

endmodule

// File: tb/tb_majority_vote_debounce.sv
// Directed and randomised checks of majority_vote_debounce over several N/HOLD variants.
`timescale 1ns/1ps
module tb_majority_vote_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_vld = 1'b0;
  logic [7:0] in_bits = '0;
  logic [7:0] mask = '0;
  logic [3:0] thr = '0;

  always #5 clk = ~clk;

  // Variant a: N=5 HOLD=3, b: N=5 HOLD=1, c: N=8 HOLD=2, d: N=1 HOLD=3
  localparam int NN  [4] = '{5, 5, 8, 1};
  localparam int HH  [4] = '{3, 1, 2, 3};
  localparam int CWS [4] = '{3, 3, 4, 1};

  logic       vld_a, raw_a, vote_a, flip_a, dis_a;
  logic       vld_b, raw_b, vote_b, flip_b, dis_b;
  logic       vld_c, raw_c, vote_c, flip_c, dis_c;
  logic       vld_d, raw_d, vote_d, flip_d, dis_d;
  logic [2:0] cnt_a, cnt_b;
  logic [3:0] cnt_c;
  logic [0:0] cnt_d;

  majority_vote_debounce #(.N(5), .HOLD(3)) u_a (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_bits(in_bits[4:0]), .mask(mask[4:0]),
    .thr(thr[2:0]), .out_vld(vld_a), .count(cnt_a), .raw(raw_a), .vote(vote_a),
    .flip(flip_a), .dissent(dis_a));
  majority_vote_debounce #(.N(5), .HOLD(1)) u_b (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_bits(in_bits[4:0]), .mask(mask[4:0]),
    .thr(thr[2:0]), .out_vld(vld_b), .count(cnt_b), .raw(raw_b), .vote(vote_b),
    .flip(flip_b), .dissent(dis_b));
  majority_vote_debounce #(.N(8), .HOLD(2)) u_c (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_bits(in_bits), .mask(mask),
    .thr(thr), .out_vld(vld_c), .count(cnt_c), .raw(raw_c), .vote(vote_c),
    .flip(flip_c), .dissent(dis_c));
  majority_vote_debounce #(.N(1), .HOLD(3)) u_d (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_bits(in_bits[0:0]), .mask(mask[0:0]),
    .thr(thr[0:0]), .out_vld(vld_d), .count(cnt_d), .raw(raw_d), .vote(vote_d),
    .flip(flip_d), .dissent(dis_d));

  logic [3:0]      o_vld, o_raw, o_vote, o_flip, o_dis;
  logic [3:0][3:0] o_cnt;
  assign o_vld  = {vld_d, vld_c, vld_b, vld_a};
  assign o_raw  = {raw_d, raw_c, raw_b, raw_a};
  assign o_vote = {vote_d, vote_c, vote_b, vote_a};
  assign o_flip = {flip_d, flip_c, flip_b, flip_a};
  assign o_dis  = {dis_d, dis_c, dis_b, dis_a};
  assign o_cnt[0] = {1'b0, cnt_a};
  assign o_cnt[1] = {1'b0, cnt_b};
  assign o_cnt[2] = cnt_c;
  assign o_cnt[3] = {3'b000, cnt_d};

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] b, input logic [7:0] mk,
                       input logic [3:0] t);
    in_vld = v; in_bits = b; mask = mk; thr = t;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 8'h00, 4'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_vld = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reference model: expected stage-2 outputs per variant, in sample order
  typedef struct packed {
    logic       vld;
    logic [3:0] cnt;
    logic       raw;
    logic       vote;
    logic       flip;
    logic       dis;
  } exp_t;

  logic       mvote [4];
  int         mdc   [4];
  logic [3:0] lcnt  [4];
  logic       lraw  [4];
  logic       ldis  [4];
  exp_t       eprev [4];
  exp_t       ecur  [4];

  task automatic model(input int i, input logic v, input logic [7:0] b,
                       input logic [7:0] mk, input logic [3:0] t, output exp_t e);
    logic [7:0] nm;
    int act, cnt, th;
    logic r, fl;
    nm = 8'((1 << NN[i]) - 1);
    fl = 1'b0;
    if (v) begin
      act = $countones(mk & nm);
      cnt = $countones(b & mk & nm);
      th  = int'(t) & ((1 << CWS[i]) - 1);
      r   = (cnt >= th);
      lcnt[i] = 4'(cnt);
      lraw[i] = r;
      ldis[i] = r ? (cnt > 0 && cnt < act) : (cnt != 0);
      if (r == mvote[i]) mdc[i] = 0;
      else if (mdc[i] + 1 == HH[i]) begin
        mvote[i] = r; mdc[i] = 0; fl = 1'b1;
      end else mdc[i] = mdc[i] + 1;
    end
    e.vld = v; e.cnt = lcnt[i]; e.raw = lraw[i];
    e.vote = mvote[i]; e.flip = fl; e.dis = ldis[i];
  endtask

  localparam logic [7:0] R1 = 8'h07;
  localparam logic [7:0] R0 = 8'h00;
  localparam logic [7:0] MALL = 8'h1F;

  logic anyf;
  logic [4:0] pat;

  initial begin
    do_reset();
    check("rst_vld",   32'(vld_a), 0);
    check("rst_cnt",   32'(cnt_a), 0);
    check("rst_raw",   32'(raw_a), 0);
    check("rst_vote",  32'(vote_a), 0);
    check("rst_flip",  32'(flip_a), 0);
    check("rst_dis",   32'(dis_a), 0);

    // HOLD=1: vote follows raw immediately
    drive(1'b1, R1, MALL, 4'd3);
    idle();
    check("h1_vld",  32'(vld_b), 1);
    check("h1_cnt",  32'(cnt_b), 3);
    check("h1_raw",  32'(raw_b), 1);
    check("h1_vote", 32'(vote_b), 1);
    check("h1_flip", 32'(flip_b), 1);
    check("h1_dis",  32'(dis_b), 1);
    check("h3_nofl", 32'(flip_a), 0);
    check("h3_vote", 32'(vote_a), 0);
    idle();
    check("h1_vld_clr",  32'(vld_b), 0);
    check("h1_flip_clr", 32'(flip_b), 0);
    check("h1_cnt_hold", 32'(cnt_b), 3);
    check("h1_vote_hold", 32'(vote_b), 1);

    // HOLD=3: three consecutive disagreeing samples
    do_reset();
    drive(1'b1, R1, MALL, 4'd3);
    drive(1'b1, R1, MALL, 4'd3);
    check("c1_vote", 32'(vote_a), 0);
    check("c1_flip", 32'(flip_a), 0);
    drive(1'b1, R1, MALL, 4'd3);
    check("c2_vote", 32'(vote_a), 0);
    check("c2_flip", 32'(flip_a), 0);
    idle();
    check("c3_vote", 32'(vote_a), 1);
    check("c3_flip", 32'(flip_a), 1);
    idle();
    check("c4_vote", 32'(vote_a), 1);
    check("c4_flip", 32'(flip_a), 0);

    // Interrupted run 1,1,0,1,1 never reaches HOLD
    do_reset();
    pat = 5'b11011;
    anyf = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, pat[i] ? R1 : R0, MALL, 4'd3);
      anyf = anyf | flip_a;
    end
    idle(); anyf = anyf | flip_a;
    idle(); anyf = anyf | flip_a;
    check("pat_flip", 32'(anyf), 0);
    check("pat_vote", 32'(vote_a), 0);

    // Valid samples separated by 4-cycle gaps
    do_reset();
    anyf = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, R1, MALL, 4'd3);
      idle();
      check($sformatf("gap_flip%0d", k), 32'(flip_a), 32'(k == 2));
      check($sformatf("gap_vote%0d", k), 32'(vote_a), 32'(k == 2));
      for (int g = 0; g < 3; g++) begin
        idle();
        anyf = anyf | flip_a;
      end
    end
    check("gap_quiet", 32'(anyf), 0);

    // Mask and threshold corners
    drive(1'b1, 8'h1C, 8'h03, 4'd2);
    drive(1'b1, 8'h1F, 8'h00, 4'd0);
    check("mk_cnt", 32'(cnt_a), 0);
    check("mk_raw", 32'(raw_a), 0);
    check("mk_dis", 32'(dis_a), 0);
    drive(1'b1, 8'h1F, 8'h1F, 4'd6);
    check("z_cnt", 32'(cnt_a), 0);
    check("z_raw", 32'(raw_a), 1);
    check("z_dis", 32'(dis_a), 0);
    idle();
    check("t6_cnt", 32'(cnt_a), 5);
    check("t6_raw", 32'(raw_a), 0);
    check("t6_dis", 32'(dis_a), 1);

    // Reset while PENDING with a sample in stage 1
    do_reset();
    drive(1'b1, R1, MALL, 4'd3);
    drive(1'b1, R1, MALL, 4'd3);
    drive(1'b1, R1, MALL, 4'd3);
    check("mf_pend_vote", 32'(vote_a), 0);
    rst = 1'b1; in_vld = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mf_rst_vld",  32'(vld_a), 0);
    check("mf_rst_vote", 32'(vote_a), 0);
    check("mf_rst_flip", 32'(flip_a), 0);
    idle();
    check("mf_drop", 32'(vld_a), 0);
    drive(1'b1, R1, MALL, 4'd3);
    drive(1'b1, R1, MALL, 4'd3);
    check("mf_d_vote", 32'(vote_a), 0);
    drive(1'b1, R1, MALL, 4'd3);
    check("mf_e_vote", 32'(vote_a), 0);
    check("mf_e_flip", 32'(flip_a), 0);
    idle();
    check("mf_f_flip", 32'(flip_a), 1);
    check("mf_f_vote", 32'(vote_a), 1);

    // Randomised run against the reference model, all variants
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mvote[i] = 1'b0; mdc[i] = 0; lcnt[i] = '0; lraw[i] = 1'b0; ldis[i] = 1'b0;
      eprev[i] = '0;
    end
    for (int k = 0; k < 10000; k++) begin
      logic v;
      logic [7:0] b, mk;
      logic [3:0] t;
      v  = ($urandom_range(0, 3) != 0);
      b  = 8'($urandom);
      mk = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      t  = 4'($urandom_range(0, 9));
      for (int i = 0; i < 4; i++) model(i, v, b, mk, t, ecur[i]);
      drive(v, b, mk, t);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("rnd%0d_vld", i),  32'(o_vld[i]),  32'(eprev[i].vld));
        check($sformatf("rnd%0d_cnt", i),  32'(o_cnt[i]),  32'(eprev[i].cnt));
        check($sformatf("rnd%0d_raw", i),  32'(o_raw[i]),  32'(eprev[i].raw));
        check($sformatf("rnd%0d_vote", i), 32'(o_vote[i]), 32'(eprev[i].vote));
        check($sformatf("rnd%0d_flip", i), 32'(o_flip[i]), 32'(eprev[i].flip));
        check($sformatf("rnd%0d_dis", i),  32'(o_dis[i]),  32'(eprev[i].dis));
        eprev[i] = ecur[i];
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
